// File: rtl/vg75_pkg.sv
// Shared constants, FSM state type and row-base arithmetic for the
// 80x25 character raster (8x16 cells, 640x400 pixels).
`timescale 1ns/1ps
package vg75_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 25;
  localparam int CELL_W = 8;
  localparam int CELL_H = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_e;

  // VRAM address of column 0 of a character row; callers truncate to
  // their address width, which gives the modulo-2^ADDR_W wrap.
  function automatic int unsigned row_base_calc(input int unsigned base,
                                                input logic [4:0]  row,
                                                input int unsigned cols);
    return base + 32'(row) * cols;
  endfunction

endpackage

// File: rtl/vram_line_buffer.sv
// Double-buffered character line buffer: one bank is filled by the row
// fetch while the other is read by the character generator.
`timescale 1ns/1ps
module vram_line_buffer #(
  parameter int COLS = 80
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_disp_bank,
  input  logic       i_wr_en,
  input  logic [6:0] i_wr_col,
  input  logic [7:0] i_wr_data,
  input  logic [6:0] i_rd_col,
  output logic [7:0] o_rd_data
);
  import vg75_pkg::*;

  localparam int DEPTH = 2 * COLS;
  localparam int IDX_W = $clog2(DEPTH);

  logic [CELL_W-1:0] r_mem [0:DEPTH-1];
  logic [CELL_W-1:0] r_rd_data;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic              w_rd_in_range;

  // Writes land in the back bank, reads come from the display bank.
  assign w_wr_idx      = (i_disp_bank ? '0 : IDX_W'(COLS)) + IDX_W'(i_wr_col);
  assign w_rd_idx      = (i_disp_bank ? IDX_W'(COLS) : '0) + IDX_W'(i_rd_col);
  assign w_rd_in_range = (i_rd_col < 7'(COLS));

  // Storage write port.
  // NOTE: the storage array has no reset; its contents are don't-care until
  // a fetch fills it, and a reset would only cost a wide clear mux.
  always_ff @(posedge clock) begin
    if (i_wr_en) r_mem[w_wr_idx] <= i_wr_data;
  end

  // Registered front-bank read; columns past the row read as zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)              r_rd_data <= '0;
    else if (w_rd_in_range) r_rd_data <= r_mem[w_rd_idx];
    else                    r_rd_data <= '0;
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/vram_fetch_arbiter.sv
// Arbitrates the single-port VRAM between the CPU bus and the per-row
// character fetch into a double-buffered line buffer.
// Build option: define VRAM_FAIR_EN to force a CPU slot after FAIR
// consecutive fetch grants; otherwise the fetch has strict priority.
`timescale 1ns/1ps
module vram_fetch_arbiter #(
  parameter int COLS      = 80,
  parameter int ADDR_W    = 14,
  parameter int VRAM_BASE = 0,
  parameter int FAIR      = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              row_start,
  input  logic [4:0]        row_idx,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic [6:0]        lb_addr,
  output logic [7:0]        lb_rdata,
  output logic              fetch_busy,
  output logic              underrun
);
  import vg75_pkg::*;

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);

  fetch_state_e      r_state, w_state_next;
  logic [6:0]        r_col;
  logic [ADDR_W-1:0] r_row_base;
  logic              r_disp_bank;
  logic              r_gen;
  logic              r_ret_valid;
  logic              r_ret_gen;
  logic [6:0]        r_ret_col;
  logic              r_cpu_ack;
  logic              r_underrun;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;

  logic              w_fetch_pending;
  logic              w_cpu_ok;
  logic              w_fair_yield;
  logic              w_fetch_grant;
  logic              w_cpu_grant;
  logic              w_ret_write;
  logic              w_last_write;
  logic [ADDR_W-1:0] w_fetch_addr;

`ifdef VRAM_FAIR_EN
  logic [7:0] r_fair_cnt;

  // Consecutive fetch grants since the last CPU slot, saturating at FAIR.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                         r_fair_cnt <= '0;
    else if (row_start || w_cpu_grant) r_fair_cnt <= '0;
    else if (w_fetch_grant && (r_fair_cnt < 8'(FAIR)))
      r_fair_cnt <= r_fair_cnt + 8'd1;
  end

  assign w_fair_yield = w_cpu_ok && (r_fair_cnt >= 8'(FAIR));
`else
  assign w_fair_yield = 1'b0;
`endif

  // One VRAM grant per cycle; a CPU request is not re-granted while its
  // ack is on the bus, which leaves that cycle to the fetch.
  always_comb begin
    w_fetch_pending = (r_state == ST_FETCH) && (r_col < 7'(COLS));
    w_cpu_ok        = cpu_req && !r_cpu_ack;
    w_fetch_grant   = w_fetch_pending && !w_fair_yield;
    w_cpu_grant     = w_cpu_ok && !w_fetch_grant;
  end

  // Fetch returns are accepted only from the current fetch generation.
  assign w_ret_write  = r_ret_valid && (r_ret_gen == r_gen);
  assign w_last_write = w_ret_write && (r_ret_col == LAST_COL);
  assign w_fetch_addr = r_row_base + ADDR_W'(r_col);

  // Next state: row_start always (re)starts a fetch, the last write ends it.
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    if (row_start)
      w_state_next = ST_FETCH;
    else if ((r_state == ST_FETCH) && w_last_write)
      w_state_next = ST_IDLE;
  end

  // State, fetch bookkeeping, return pipeline and held grant outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_col       <= '0;
      r_row_base  <= '0;
      r_disp_bank <= 1'b0;
      r_gen       <= 1'b0;
      r_ret_valid <= 1'b0;
      r_ret_gen   <= 1'b0;
      r_ret_col   <= '0;
      r_cpu_ack   <= 1'b0;
      r_underrun  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_next;
      r_underrun  <= row_start && (r_state == ST_FETCH);
      r_cpu_ack   <= w_cpu_grant;
      r_ret_valid <= w_fetch_grant;
      r_ret_col   <= r_col;
      r_ret_gen   <= r_gen;
      if (row_start) begin
        r_disp_bank <= ~r_disp_bank;
        r_gen       <= ~r_gen;
        r_col       <= '0;
        r_row_base  <= ADDR_W'(row_base_calc(VRAM_BASE, row_idx, COLS));
      end else if (w_fetch_grant) begin
        r_col <= r_col + 7'd1;
      end
      if (w_fetch_grant) begin
        r_mem_addr <= w_fetch_addr;
      end else if (w_cpu_grant) begin
        r_mem_addr  <= cpu_addr;
        r_mem_wdata <= cpu_wdata;
      end
    end
  end

  assign mem_addr   = w_fetch_grant ? w_fetch_addr :
                      w_cpu_grant   ? cpu_addr     : r_mem_addr;
  assign mem_we     = w_cpu_grant && cpu_we;
  assign mem_wdata  = w_cpu_grant ? cpu_wdata : r_mem_wdata;
  assign cpu_ack    = r_cpu_ack;
  assign cpu_rdata  = r_cpu_ack ? mem_rdata : 8'h00;
  assign fetch_busy = (r_state == ST_FETCH);
  assign underrun   = r_underrun;

  vram_line_buffer #(.COLS(COLS)) u_line_buffer (
    .clock       (clock),
    .reset       (reset),
    .i_disp_bank (r_disp_bank),
    .i_wr_en     (w_ret_write),
    .i_wr_col    (r_ret_col),
    .i_wr_data   (mem_rdata),
    .i_rd_col    (lb_addr),
    .o_rd_data   (lb_rdata)
  );

endmodule

// File: tb/tb_vram_fetch_arbiter.sv
// Directed + randomized bench for vram_fetch_arbiter with a behavioural
// VRAM, a CPU-side reference memory and row-arithmetic expectations.
`timescale 1ns/1ps
module tb_vram_fetch_arbiter;

  localparam int COLS      = 80;
  localparam int ADDR_W    = 14;
  localparam int VRAM_BASE = 0;
  localparam int MEM_SIZE  = 1 << ADDR_W;
  localparam int IDLE_BUSY = COLS + 1;        // grants 1..COLS, last write at COLS+1
`ifdef VRAM_FAIR_EN
  localparam int EXP_CONT_BUSY  = 100;        // 99 grants + final return cycle
  localparam int EXP_CONT_ACKS  = 19;
  localparam int EXP_FIRST_ACK  = 6;          // CPU slot after 4 fetch grants
`else
  localparam int EXP_CONT_BUSY  = COLS + 1;
  localparam int EXP_CONT_ACKS  = 0;
  localparam int EXP_FIRST_ACK  = COLS + 2;   // CPU takes the slot after the last fetch grant
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              row_start;
  logic [4:0]        row_idx;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = 8'h00;
  logic [6:0]        lb_addr;
  logic [7:0]        lb_rdata;
  logic              fetch_busy;
  logic              underrun;

  int checks   = 0;
  int failures = 0;

  vram_fetch_arbiter #(
    .COLS(COLS), .ADDR_W(ADDR_W), .VRAM_BASE(VRAM_BASE), .FAIR(4)
  ) dut (
    .clock(clock), .reset(reset), .row_start(row_start), .row_idx(row_idx),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .lb_addr(lb_addr),
    .lb_rdata(lb_rdata), .fetch_busy(fetch_busy), .underrun(underrun)
  );

  always #5 clock = ~clock;

  // Behavioural VRAM: unwritten locations hold the low address byte.
  logic [7:0] vram_w [int];
  always @(posedge clock) begin
    mem_rdata <= vram_w.exists(int'(mem_addr)) ? vram_w[int'(mem_addr)] : 8'(mem_addr);
    if (mem_we) vram_w[int'(mem_addr)] = mem_wdata;
  end

  // Reference contents, updated only from the bench's own CPU writes.
  logic [7:0] ref_w [int];

  function automatic logic [7:0] ref_byte(input int a);
    return ref_w.exists(a) ? ref_w[a] : 8'(a);
  endfunction

  function automatic logic [7:0] exp_row_byte(input int row, input int c);
    return ref_byte((VRAM_BASE + row * COLS + c) % MEM_SIZE);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_cpu_ack"},    32'(cpu_ack),    0);
    check({tag, "_cpu_rdata"},  32'(cpu_rdata),  0);
    check({tag, "_mem_addr"},   32'(mem_addr),   0);
    check({tag, "_mem_we"},     32'(mem_we),     0);
    check({tag, "_mem_wdata"},  32'(mem_wdata),  0);
    check({tag, "_lb_rdata"},   32'(lb_rdata),   0);
    check({tag, "_fetch_busy"}, 32'(fetch_busy), 0);
    check({tag, "_underrun"},   32'(underrun),   0);
  endtask

  task automatic pulse_row(input int idx);
    row_idx   = 5'(idx);
    row_start = 1'b1;
    tick();
    row_start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (fetch_busy && n < 400) begin
      n++;
      tick();
    end
  endtask

  task automatic run_row(input int idx, input string tag);
    int n;
    pulse_row(idx);
    wait_idle(n);
    check(tag, 32'(n), 32'(IDLE_BUSY));
  endtask

  // Reads every column of the front bank, starting at a random column.
  task automatic check_front(input int row, input string tag);
    int start;
    start = $urandom_range(0, COLS - 1);
    for (int i = 0; i < COLS; i++) begin
      int c;
      c = (start + i) % COLS;
      lb_addr = 7'(c);
      tick();
      check(tag, 32'(lb_rdata), 32'(exp_row_byte(row, c)));
    end
  endtask

  task automatic cpu_access(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [7:0] wdata, output logic [7:0] rdata,
                            output int lat);
    cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    lat = 0;
    @(negedge clock);
    while (!cpu_ack && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    rdata = cpu_rdata;
    @(posedge clock);
    #1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    if (we) ref_w[int'(addr)] = wdata;
  endtask

  initial begin
    logic [7:0] rd;
    int         lat, n, k, first_ack, busy_acks, ucnt, prev;

    reset = 1'b1; row_start = 1'b0; row_idx = '0; cpu_req = 1'b0;
    cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; lb_addr = '0;
    #23;
    check_outputs_zero("reset");
    @(posedge clock);
    #1 reset = 1'b0;
    tick();

    // Idle row fetch: row 2 lands in the back bank, row 3 swaps it to the front.
    run_row(2, "busy_row2");
    run_row(3, "busy_row3");
    check_front(2, "lb_row2");

    // CPU write then read-back while no fetch is running.
    cpu_access(1'b1, 14'h0123, 8'h5A, rd, lat);
    check("cpu_wr_latency", 32'(lat), 1);
    cpu_access(1'b0, 14'h0123, 8'h00, rd, lat);
    check("cpu_rd_latency", 32'(lat), 1);
    check("cpu_rd_data", 32'(rd), 32'h5A);

    // Contention: CPU read request held from the first fetch cycle.
    pulse_row(4);
    cpu_we = 1'b0; cpu_addr = 14'h0200; cpu_req = 1'b1;
    k = 1; first_ack = 0; busy_acks = 0; n = 0;
    while (k < 400) begin
      if (cpu_ack && first_ack == 0) first_ack = k;
      if (cpu_ack && fetch_busy) busy_acks++;
      if (!fetch_busy) begin
        cpu_req = 1'b0;
        break;
      end
      n++;
      k++;
      tick();
    end
    check("cont_busy_cycles", 32'(n), 32'(EXP_CONT_BUSY));
    check("cont_acks_in_fetch", 32'(busy_acks), 32'(EXP_CONT_ACKS));
    check("cont_first_ack", 32'(first_ack), 32'(EXP_FIRST_ACK));
    tick();
    run_row(6, "busy_row6");
    check_front(4, "lb_row4");

    // Randomized CPU traffic against the reference memory.
    for (int i = 0; i < 24; i++) begin
      logic              we;
      logic [ADDR_W-1:0] a;
      logic [7:0]        d;
      we = 1'($urandom_range(0, 1));
      a  = ADDR_W'($urandom_range(0, MEM_SIZE - 1));
      if (i % 4 == 3) a = ADDR_W'(VRAM_BASE + 10 * COLS + $urandom_range(0, COLS - 1));
      d  = 8'($urandom);
      if (we) begin
        cpu_access(1'b1, a, d, rd, lat);
        check("rnd_wr_latency", 32'(lat), 1);
      end else begin
        cpu_access(1'b0, a, 8'h00, rd, lat);
        check("rnd_rd_latency", 32'(lat), 1);
        check("rnd_rd_data", 32'(rd), 32'(ref_byte(int'(a))));
      end
    end

    // Randomized rows, including row 10 which may carry CPU-written bytes.
    prev = 6;
    for (int i = 0; i < 3; i++) begin
      int r;
      r = (i == 0) ? 10 : $urandom_range(0, 24);
      run_row(r, "busy_rnd_row");
      check_front(prev, "lb_rnd_row");
      prev = r;
    end
    run_row(24, "busy_row24");
    check_front(prev, "lb_rnd_last");

    // Underrun: second row_start at fetch cycle 40.
    ucnt = 0;
    pulse_row(2);
    for (int i = 0; i < 39; i++) begin
      if (underrun) ucnt++;
      tick();
    end
    row_idx   = 5'd5;
    row_start = 1'b1;
    tick();
    row_start = 1'b0;
    n = 0;
    while (fetch_busy && n < 400) begin
      if (underrun) ucnt++;
      n++;
      tick();
    end
    check("underrun_pulses", 32'(ucnt), 1);
    check("underrun_busy", 32'(n), 32'(IDLE_BUSY));
    run_row(0, "busy_row0");
    check_front(5, "lb_row5");

    // Reset mid-fetch, asynchronously between clock edges.
    pulse_row(7);
    for (int i = 0; i < 29; i++) tick();
    lb_addr = 7'd17;
    #3 reset = 1'b1;
    #1;
    check_outputs_zero("midreset");
    @(posedge clock);
    #1 reset = 1'b0;
    tick();
    run_row(9, "busy_row9");
    run_row(1, "busy_row1");
    check_front(9, "lb_row9");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
